// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search engine.
// State encodings, index-width helper and comparator one-hot check.
package sar_search_pkg;

  localparam logic [1:0] SAR_IDLE = 2'd0;
  localparam logic [1:0] SAR_TEST = 2'd1;
  localparam logic [1:0] SAR_DONE = 2'd2;

  // Width of the bit index for a given operand width (never below 1).
  function automatic int unsigned sar_idx_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // True when exactly one of the three comparator outputs is high.
  function automatic logic cmp_onehot(input logic eq, input logic gt, input logic lt);
    return (eq ^ gt ^ lt) & ~(eq & gt & lt);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search engine driving the B operand of an external
// magnitude comparator and resolving the hidden A operand MSB-first.
// Optional feature: define SAR_EARLY_EXIT_EN to finish as soon as the
// comparator reports a valid equality.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cmp_eq_i,
  input  logic             cmp_gt_i,
  input  logic             cmp_lt_i,
  output logic [WIDTH-1:0] trial_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  localparam int unsigned IdxW = sar_idx_w(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] trial_upd;
  logic [IdxW-1:0]  idx_m1;
  logic             cmp_valid;

  assign cmp_valid = cmp_onehot(cmp_eq_i, cmp_gt_i, cmp_lt_i);
  assign idx_m1    = idx_q - IdxW'(1);

  // Next-state: accept, one decision per TEST edge, single DONE cycle.
  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    result_d  = result_q;
    idx_d     = idx_q;
    err_d     = err_q;
    trial_upd = trial_q;

    unique case (state_q)
      SAR_IDLE: begin
        if (start_i) begin
          state_d = SAR_TEST;
          trial_d = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d   = IdxW'(WIDTH-1);
          err_d   = 1'b0;
        end
      end
      SAR_TEST: begin
        if (!cmp_valid) begin
          err_d = 1'b1;
        end
`ifdef SAR_EARLY_EXIT_EN
        if (cmp_valid && cmp_eq_i) begin
          state_d  = SAR_DONE;
          result_d = trial_q;
        end else
`endif
        begin
          // Only cmp_lt steers the decision, even when the inputs are invalid.
          if (cmp_lt_i) begin
            trial_upd[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            state_d  = SAR_DONE;
            result_d = trial_upd;
          end else begin
            trial_upd[idx_m1] = 1'b1;
            idx_d             = idx_m1;
          end
          trial_d = trial_upd;
        end
      end
      SAR_DONE: begin
        state_d = SAR_IDLE;
      end
      default: begin
        state_d = SAR_IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort to the reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SAR_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= IdxW'(WIDTH-1);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign trial_o  = trial_q;
  assign result_o = result_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q == SAR_TEST);
  assign done_o   = (state_q == SAR_DONE);

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural 4-bit comparator in the loop, results
// scoreboarded on each done pulse, trial/busy/done checked cycle by cycle.
module tb_sar_search;

  localparam int unsigned W = 4;
`ifdef SAR_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         cmp_eq, cmp_gt, cmp_lt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;

  logic [W-1:0] target;
  logic         fault;

  int errors;
  int checks;
  int done_cnt;
  logic [4:0] exp_q[$];

  // Comparator A=target, B=trial; fault forces gt=lt=1.
  assign cmp_eq = fault ? 1'b0 : (target == trial);
  assign cmp_gt = fault ? 1'b1 : (target > trial);
  assign cmp_lt = fault ? 1'b1 : (target < trial);

  sar_search #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .cmp_eq_i (cmp_eq),
    .cmp_gt_i (cmp_gt),
    .cmp_lt_i (cmp_lt),
    .trial_o  (trial),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference SAR: trial sequence, decision-edge count and converged value.
  function automatic int sar_model(input logic [W-1:0] a, output logic [15:0] seq,
                                   output logic [W-1:0] res);
    logic [W-1:0] acc;
    logic [W-1:0] t;
    int n;
    acc = '0;
    seq = '0;
    n   = 0;
    for (int b = W - 1; b >= 0; b--) begin
      t = acc | W'(1 << b);
      seq[n*4 +: 4] = t;
      n++;
      if (Early && t == a) begin
        res = t;
        return n;
      end
      if (t <= a) acc = t;
    end
    res = acc;
    return n;
  endfunction

  // Scoreboard: every done pulse pops one expected {result, err}.
  always @(negedge clk) begin
    logic [4:0] e;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", 32'(result), 32'(e[4:1]));
        check_eq("err_at_done", 32'(err), 32'(e[0]));
      end
    end
  end

  // One search with start pulsed; optionally corrupt the bit-1 decision.
  task automatic run_search(input logic [W-1:0] a, input bit fault_bit1);
    logic [15:0]  seq;
    logic [W-1:0] res;
    int n;
    n = sar_model(a, seq, res);
    @(posedge clk);
    @(negedge clk);
    target = a;
    start  = 1'b1;
    exp_q.push_back({res, fault_bit1});
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check_eq("trial", 32'(trial), 32'(seq[k*4 +: 4]));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("done_early", 32'(done), 32'd0);
      if (k == 0) check_eq("err_cleared", 32'(err), 32'd0);
      fault = fault_bit1 && (k == W - 2);
      @(posedge clk);
      #1 fault = 1'b0;
    end
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq("trial_held", 32'(trial), 32'(Early ? seq[(n-1)*4 +: 4] : {28'd0, res}));
  endtask

  initial begin
    logic [15:0]  seq;
    logic [W-1:0] res;
    int n;
    int t_done[3];
    int cyc;
    int nd;
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    start    = 1'b0;
    fault    = 1'b0;
    target   = '0;
    rst_n    = 1'b0;
    #12;
    check_eq("rst_trial", 32'(trial), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run_search(4'd9, 1'b0);
    run_search(4'd0, 1'b0);
    run_search(4'd15, 1'b0);
    run_search(4'd8, 1'b0);
    run_search(4'd5, 1'b1);
    run_search(4'd5, 1'b0);
    for (int i = 0; i < 4; i++) run_search(4'($urandom_range(0, 15)), 1'b0);

    // Reset during the bit-2 decision cycle aborts with no done.
    @(posedge clk);
    @(negedge clk);
    target = 4'd9;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 check_eq("pre_rst_trial", 32'(trial), 32'd12);
    rst_n = 1'b0;
    #1;
    check_eq("arst_trial", 32'(trial), 32'd0);
    check_eq("arst_result", 32'(result), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_search(4'd3, 1'b0);

    // Start held high: back-to-back searches at the minimum period.
    n  = sar_model(4'd6, seq, res);
    nd = 0;
    @(posedge clk);
    @(negedge clk);
    target = 4'd6;
    start  = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({res, 1'b0});
    cyc = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        t_done[nd] = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    check_eq("hold_done_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check_eq("hold_first_lat", 32'(t_done[0]), 32'(n + 1));
      check_eq("hold_period1", 32'(t_done[1] - t_done[0]), 32'(n + 2));
      check_eq("hold_period2", 32'(t_done[2] - t_done[1]), 32'(n + 2));
    end
    repeat (4) @(posedge clk);
    #1 check_eq("hold_idle_after", 32'(busy), 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("total_dones", 32'(done_cnt), 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
